// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_pkg
// Description : Shared types and constants for the 7-segment scan controller.
//               Provides the active-low segment codes, the scan FSM state
//               encoding, and the BCD-to-segment decode function.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

    // Segment order is {a,b,c,d,e,f,g}; a low bit lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100   // 9
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    // Non-decimal codes (10..15) show nothing rather than a garbage glyph.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] w_seg;
        w_seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (bcd == 4'(i)) begin
                w_seg = SEG_DIGIT[i];
            end
        end
        return w_seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_slot_timer
// Description : Slot counter and digit index for the display scan. Each slot
//               lasts PRESCALE cycles, the first BLANK_CYCLES of which are
//               the anti-ghosting blank. Flags slot and frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_slot_timer #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500,
    localparam int CW = $clog2(PRESCALE),
    localparam int DW = $clog2(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_run,
    input  logic          i_clear,
    output logic [DW-1:0] o_digit,
    output logic          o_in_blank,
    output logic          o_blank_end,
    output logic          o_slot_end,
    output logic          o_frame_wrap
);

    localparam logic [CW-1:0] c_cnt_last   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] c_blank_len  = CW'(BLANK_CYCLES);
    localparam logic [CW-1:0] c_blank_last = CW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] c_dig_last   = DW'(NUM_DIGITS - 1);

    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_dig;

    // Count cycles within a slot; advance the digit when the slot expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_dig <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_dig <= '0;
        end else if (i_run) begin
            if (r_cnt == c_cnt_last) begin
                r_cnt <= '0;
                r_dig <= (r_dig == c_dig_last) ? '0 : r_dig + DW'(1);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_digit      = r_dig;
    assign o_in_blank   = (r_cnt < c_blank_len);
    assign o_blank_end  = (r_cnt == c_blank_last);
    assign o_slot_end   = (r_cnt == c_cnt_last);
    assign o_frame_wrap = o_slot_end && (r_dig == c_dig_last);

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed common-anode 7-segment scan controller.
//               One decode path is shared across NUM_DIGITS digits. Host
//               values enter a shadow buffer via valid/ready and are only
//               committed at frame boundaries (or at once while scanning is
//               disabled), so a frame never mixes old and new digits.
//               Optional macro LEADING_ZERO_BLANK_EN suppresses leading
//               zeros on digits above digit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int DW = $clog2(NUM_DIGITS);

    scan_state_e             r_state;
    scan_state_e             w_state_nxt;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic                    r_pending;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_run;
    logic                    w_clear;
    logic                    w_accept;
    logic                    w_wrap;
    logic                    w_commit;
    logic                    w_drive;
    logic [DW-1:0]           w_digit;
    logic                    w_in_blank;
    logic                    w_blank_end;
    logic                    w_slot_end;
    logic                    w_frame_wrap;
    logic [3:0]              w_digit_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_blank_dig;

    assign w_run   = en && (r_state != IDLE);
    assign w_clear = !en;

    scan_slot_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_run        (w_run),
        .i_clear      (w_clear),
        .o_digit      (w_digit),
        .o_in_blank   (w_in_blank),
        .o_blank_end  (w_blank_end),
        .o_slot_end   (w_slot_end),
        .o_frame_wrap (w_frame_wrap)
    );

    // Scan FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: blank then drive each slot; dropping en always parks in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = BLANK;
                BLANK:   if (w_blank_end) w_state_nxt = DRIVE;
                DRIVE:   if (w_slot_end)  w_state_nxt = BLANK;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // A commit needs pending set and an accept needs it clear, so the two
    // never collide and a value accepted at a frame wrap waits a full frame.
    assign load_ready = !r_pending;
    assign w_accept   = load_valid && !r_pending;
    assign w_wrap     = w_run && (r_state == DRIVE) && w_frame_wrap;
    assign w_commit   = r_pending && (w_wrap || !en);

    // Shadow capture on handshake; active update at commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else if (w_commit) begin
            r_active  <= r_shadow;
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_shadow  <= load_data;
            r_pending <= 1'b1;
        end
    end

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digits
            assign w_digit_val[k] = r_active[4*k +: 4];
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a digit blanks while it and everything above are zero.
    always_comb begin
        logic w_zeros;
        w_blank_dig = '0;
        w_zeros     = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            w_zeros        = w_zeros && (w_digit_val[k] == 4'd0);
            w_blank_dig[k] = w_zeros;
        end
    end
`else
    assign w_blank_dig = '0;
`endif

    assign w_drive = en && (r_state == DRIVE) && !w_in_blank;

    // Registered display outputs, one cycle behind the scan state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg        <= SEG_BLANK;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_drive) begin
                r_an  <= ~(NUM_DIGITS'(1) << w_digit);
                r_seg <= w_blank_dig[w_digit] ? SEG_BLANK
                                              : bcd_to_seg(w_digit_val[w_digit]);
            end else begin
                r_an  <= '1;
                r_seg <= SEG_BLANK;
            end
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Directed self-checking bench for seg_scan_ctrl with
//               NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1.
//               Honours LEADING_ZERO_BLANK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int PS = 4;
    localparam int BC = 1;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        en         = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data  = 16'h0;
    logic        load_ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (PS),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference segment table (active-low a..g).
    function automatic logic [6:0] ref_dec(input logic [3:0] b);
        case (b)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Cycle i counts edges since en rose (i=1 is the first). Outputs trail the
    // state by one cycle, so from i=2 on each 16-cycle frame is four slots of
    // one blank cycle followed by three drive cycles.
    function automatic logic [3:0] exp_an(input int i);
        int p;
        if (i < 2) return 4'hF;
        p = (i - 2) % 16;
        if (p % 4 == 0) return 4'hF;
        return ~(4'b0001 << (p / 4));
    endfunction

    function automatic logic [6:0] exp_seg(input int i, input logic [15:0] v);
        int p;
        int s;
        if (i < 2) return 7'h7F;
        p = (i - 2) % 16;
        if (p % 4 == 0) return 7'h7F;
        s = p / 4;
`ifdef LEADING_ZERO_BLANK_EN
        if (s > 0 && (v >> (4 * s)) == 16'h0) return 7'h7F;
`endif
        return ref_dec(v[s*4 +: 4]);
    endfunction

    function automatic logic exp_fd(input int i);
        return (i >= 17) && ((i - 1) % 16 == 0);
    endfunction

    task automatic do_reset();
        rst        = 1'b1;
        en         = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg got=%b exp=%b", seg, 7'h7F); end
        n_cmp++; if (an !== 4'hF) begin n_err++; $display("FAIL reset_an got=%b exp=%b", an, 4'hF); end
        n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (an !== exp_an(i)) begin n_err++; $display("FAIL scan_an i=%0d got=%b exp=%b", i, an, exp_an(i)); end
            n_cmp++; if (seg !== exp_seg(i, 16'h0)) begin n_err++; $display("FAIL scan_seg i=%0d got=%b exp=%b", i, seg, exp_seg(i, 16'h0)); end
            n_cmp++; if (frame_done !== exp_fd(i)) begin n_err++; $display("FAIL scan_fd i=%0d got=%b exp=%b", i, frame_done, exp_fd(i)); end
            n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL scan_ready i=%0d got=%b exp=1", i, load_ready); end
        end
    endtask

    // One load at cycle 3; it becomes visible in the second frame.
    task automatic test_single_load(input string nm, input logic [15:0] v);
        logic [15:0] v_exp;
        logic        r_exp;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            v_exp = (i < 18) ? 16'h0 : v;
            r_exp = (i <= 3) || (i >= 17);
            n_cmp++; if (an !== exp_an(i)) begin n_err++; $display("FAIL %s_an i=%0d got=%b exp=%b", nm, i, an, exp_an(i)); end
            n_cmp++; if (seg !== exp_seg(i, v_exp)) begin n_err++; $display("FAIL %s_seg i=%0d got=%b exp=%b", nm, i, seg, exp_seg(i, v_exp)); end
            n_cmp++; if (frame_done !== exp_fd(i)) begin n_err++; $display("FAIL %s_fd i=%0d got=%b exp=%b", nm, i, frame_done, exp_fd(i)); end
            n_cmp++; if (load_ready !== r_exp) begin n_err++; $display("FAIL %s_ready i=%0d got=%b exp=%b", nm, i, load_ready, r_exp); end
            if (i == 3) begin load_valid = 1'b1; load_data = v; end
            if (i == 4) begin load_valid = 1'b0; load_data = 16'hFFFF; end
        end
    endtask

    // Second value held valid while the first is pending: taken after commit.
    task automatic test_back_to_back();
        logic [15:0] v_exp;
        logic        r_exp;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            v_exp = (i < 18) ? 16'h0 : (i < 34) ? 16'h1234 : 16'h5678;
            r_exp = (i <= 3) || (i == 17) || (i >= 33);
            n_cmp++; if (an !== exp_an(i)) begin n_err++; $display("FAIL b2b_an i=%0d got=%b exp=%b", i, an, exp_an(i)); end
            n_cmp++; if (seg !== exp_seg(i, v_exp)) begin n_err++; $display("FAIL b2b_seg i=%0d got=%b exp=%b", i, seg, exp_seg(i, v_exp)); end
            n_cmp++; if (frame_done !== exp_fd(i)) begin n_err++; $display("FAIL b2b_fd i=%0d got=%b exp=%b", i, frame_done, exp_fd(i)); end
            n_cmp++; if (load_ready !== r_exp) begin n_err++; $display("FAIL b2b_ready i=%0d got=%b exp=%b", i, load_ready, r_exp); end
            if (i == 3)  begin load_valid = 1'b1; load_data = 16'h1234; end
            if (i == 4)  load_data = 16'h5678;
            if (i == 18) begin load_valid = 1'b0; load_data = 16'h0; end
        end
    endtask

    // en dropped mid-DRIVE of digit 2; a load while idle commits at once.
    task automatic test_en_toggle();
        logic r_exp;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk); #1;
        end
        n_cmp++; if (an !== 4'b1011) begin n_err++; $display("FAIL en_pre_an got=%b exp=%b", an, 4'b1011); end
        en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            r_exp = (k != 2);
            n_cmp++; if (an !== 4'hF) begin n_err++; $display("FAIL en_idle_an k=%0d got=%b exp=%b", k, an, 4'hF); end
            n_cmp++; if (seg !== 7'h7F) begin n_err++; $display("FAIL en_idle_seg k=%0d got=%b exp=%b", k, seg, 7'h7F); end
            n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL en_idle_fd k=%0d got=%b exp=0", k, frame_done); end
            n_cmp++; if (load_ready !== r_exp) begin n_err++; $display("FAIL en_idle_ready k=%0d got=%b exp=%b", k, load_ready, r_exp); end
            if (k == 1) begin load_valid = 1'b1; load_data = 16'h0987; end
            if (k == 2) begin load_valid = 1'b0; load_data = 16'h0; end
            if (k == 5) en = 1'b1;
        end
        for (int j = 1; j <= 18; j++) begin
            @(posedge clk); #1;
            n_cmp++; if (an !== exp_an(j)) begin n_err++; $display("FAIL en_re_an j=%0d got=%b exp=%b", j, an, exp_an(j)); end
            n_cmp++; if (seg !== exp_seg(j, 16'h0987)) begin n_err++; $display("FAIL en_re_seg j=%0d got=%b exp=%b", j, seg, exp_seg(j, 16'h0987)); end
            n_cmp++; if (frame_done !== exp_fd(j)) begin n_err++; $display("FAIL en_re_fd j=%0d got=%b exp=%b", j, frame_done, exp_fd(j)); end
        end
    endtask

    // Reset between edges with a value pending: everything returns to idle.
    task automatic test_reset_mid();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin load_valid = 1'b1; load_data = 16'h1234; end
            if (i == 4) begin load_valid = 1'b0; load_data = 16'h0; end
        end
        n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_pend got=%b exp=0", load_ready); end
        n_cmp++; if (an !== 4'b1101) begin n_err++; $display("FAIL rstmid_pre_an got=%b exp=%b", an, 4'b1101); end
        rst = 1'b1;
        #1;
        n_cmp++; if (seg !== 7'h7F) begin n_err++; $display("FAIL rstmid_seg got=%b exp=%b", seg, 7'h7F); end
        n_cmp++; if (an !== 4'hF) begin n_err++; $display("FAIL rstmid_an got=%b exp=%b", an, 4'hF); end
        n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got=%b exp=1", load_ready); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rstmid_fd got=%b exp=0", frame_done); end
        #1;
        rst = 1'b0;
        for (int j = 1; j <= 34; j++) begin
            @(posedge clk); #1;
            n_cmp++; if (an !== exp_an(j)) begin n_err++; $display("FAIL rstmid_re_an j=%0d got=%b exp=%b", j, an, exp_an(j)); end
            n_cmp++; if (seg !== exp_seg(j, 16'h0)) begin n_err++; $display("FAIL rstmid_re_seg j=%0d got=%b exp=%b", j, seg, exp_seg(j, 16'h0)); end
            n_cmp++; if (frame_done !== exp_fd(j)) begin n_err++; $display("FAIL rstmid_re_fd j=%0d got=%b exp=%b", j, frame_done, exp_fd(j)); end
            n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_re_ready j=%0d got=%b exp=1", j, load_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_single_load("load", 16'h1234);
        test_back_to_back();
        test_single_load("invalid", 16'hF90A);
        test_single_load("lzero", 16'h0050);
        test_en_toggle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
